// File: rtl/nibble_sequencer_if.sv
// Control/status bundle between the nibble sequencer and the datapath/debug host.
interface nibble_sequencer_if;
  logic       run;
  logic       step_req;
  logic [2:0] ir_op;
  logic       fetch_en;
  logic       opnd_en;
  logic       r_en;
  logic       ram_we;
  logic       step_ack;
  logic       halted;
  logic [2:0] state;
  logic [7:0] instr_count;

  modport master (
    output run, step_req, ir_op,
    input  fetch_en, opnd_en, r_en, ram_we, step_ack, halted, state, instr_count
  );

  modport slave (
    input  run, step_req, ir_op,
    output fetch_en, opnd_en, r_en, ram_we, step_ack, halted, state, instr_count
  );
endinterface

// File: rtl/nibble_sequencer.sv
// Moore control sequencer: fetch/decode/memread/exec/store with run and single-step
// modes, configurable ROM/RAM wait states and a retired-instruction counter.
module nibble_sequencer #(
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  nibble_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEMRD  = 3'd3,
    EXEC   = 3'd4,
    STORE  = 3'd5,
    HALT   = 3'd6,
    BAD    = 3'd7
  } state_e;

  localparam logic [1:0] ROM_LAST = 2'(ROM_WAIT - 1);
  localparam logic [1:0] RAM_LAST = 2'(RAM_WAIT - 1);

  state_e     state_q, state_d;
  logic [1:0] wait_q, wait_d;
  logic       step_q, step_d;
  logic       ack_q, ack_d;
  logic [7:0] cnt_q, cnt_d;
  logic       retire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= 2'd0;
      step_q  <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      step_q  <= step_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    step_d  = step_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        // run has priority; a step request only arms the flag when not running
        if (bus.run) begin
          state_d = FETCH;
          step_d  = 1'b0;
        end else if (bus.step_req) begin
          state_d = FETCH;
          step_d  = 1'b1;
        end
      end
      FETCH: begin
        if (wait_q == ROM_LAST) begin
          wait_d  = 2'd0;
          state_d = DECODE;
        end else begin
          wait_d  = wait_q + 2'd1;
        end
      end
      DECODE: begin
        if (bus.ir_op == 3'b111)      state_d = HALT;
        else if (bus.ir_op == 3'b100) state_d = STORE;
        else if (bus.ir_op[0])        state_d = MEMRD;
        else                          state_d = EXEC;
      end
      MEMRD: begin
        if (wait_q == RAM_LAST) begin
          wait_d  = 2'd0;
          state_d = EXEC;
        end else begin
          wait_d  = wait_q + 2'd1;
        end
      end
      EXEC:  retire = 1'b1;
      STORE: retire = 1'b1;
      HALT:  state_d = HALT;
      default: begin
        state_d = IDLE;
        wait_d  = 2'd0;
        step_d  = 1'b0;
      end
    endcase

    if (retire) begin
      cnt_d = cnt_q + 8'd1;
      if (step_q) begin
        state_d = IDLE;
        step_d  = 1'b0;
        ack_d   = 1'b1;
      end else if (bus.run) begin
        state_d = FETCH;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign bus.fetch_en    = (state_q == FETCH) && (wait_q == ROM_LAST);
  assign bus.opnd_en     = (state_q == DECODE);
  assign bus.r_en        = (state_q == EXEC);
  assign bus.ram_we      = (state_q == STORE);
  assign bus.step_ack    = ack_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.state       = state_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_nibble_sequencer.sv
// Directed bench: per-cycle expected output snapshots are queued ahead of each
// stimulus step and popped/compared one per clock on the falling edge.
module tb_nibble_sequencer;

  logic clk;
  logic ra, rb, rc;

  nibble_sequencer_if ifa ();
  nibble_sequencer_if ifb ();
  nibble_sequencer_if ifc ();

  nibble_sequencer #(.ROM_WAIT(1), .RAM_WAIT(1)) dut_a (.clk(clk), .reset(ra), .bus(ifa.slave));
  nibble_sequencer #(.ROM_WAIT(3), .RAM_WAIT(2)) dut_b (.clk(clk), .reset(rb), .bus(ifb.slave));
  nibble_sequencer #(.ROM_WAIT(2), .RAM_WAIT(3)) dut_c (.clk(clk), .reset(rc), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_M = 3'd3,
                         S_E = 3'd4, S_S = 3'd5, S_H = 3'd6;
  // {fetch_en, opnd_en, r_en, ram_we, step_ack, halted}
  localparam logic [5:0] E0 = 6'b000000, EF = 6'b100000, EO = 6'b010000,
                         ER = 6'b001000, EW = 6'b000100, EA = 6'b000010,
                         EH = 6'b000001;

  typedef logic [16:0] vec_t;
  typedef struct { int sel; vec_t v; } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t obs(int sel);
    case (sel)
      0: return {ifa.state, ifa.fetch_en, ifa.opnd_en, ifa.r_en, ifa.ram_we,
                 ifa.step_ack, ifa.halted, ifa.instr_count};
      1: return {ifb.state, ifb.fetch_en, ifb.opnd_en, ifb.r_en, ifb.ram_we,
                 ifb.step_ack, ifb.halted, ifb.instr_count};
      default: return {ifc.state, ifc.fetch_en, ifc.opnd_en, ifc.r_en, ifc.ram_we,
                       ifc.step_ack, ifc.halted, ifc.instr_count};
    endcase
  endfunction

  task automatic push(input int sel, input logic [2:0] st, input logic [5:0] en,
                      input logic [7:0] c);
    exp_t e;
    e.sel = sel;
    e.v   = {st, en, c};
    q.push_back(e);
  endtask

  task automatic step(input int n);
    exp_t e;
    vec_t o;
    string tag;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $error("FAIL scoreboard_empty#%0d: got no expectation, required one queued", n_cmp);
      end else begin
        e   = q.pop_front();
        o   = obs(e.sel);
        tag = $sformatf("dut%0d_cyc%0d", e.sel, n_cmp);
        assert (o === e.v) else begin
          n_err++;
          $error("FAIL %s: got st=%0d en=%b cnt=%0d, want st=%0d en=%b cnt=%0d",
                 tag, o[16:14], o[13:8], o[7:0], e.v[16:14], e.v[13:8], e.v[7:0]);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    ifa.run = 1'b0; ifa.step_req = 1'b0; ifa.ir_op = 3'd0;
    ifb.run = 1'b0; ifb.step_req = 1'b0; ifb.ir_op = 3'd0;
    ifc.run = 1'b0; ifc.step_req = 1'b0; ifc.ir_op = 3'd0;
    @(negedge clk);

    // reset state
    push(0, S_I, E0, 0); step(1);

    // free-running ALU ops
    ra = 1'b1; ifa.run = 1'b1; ifa.ir_op = 3'b000;
    for (int i = 0; i < 2; i++) begin
      push(0, S_F, EF, 8'(i)); push(0, S_D, EO, 8'(i)); push(0, S_E, ER, 8'(i));
    end
    push(0, S_F, EF, 2); step(7);
    ifa.run = 1'b0;
    push(0, S_D, EO, 2); push(0, S_E, ER, 2); push(0, S_I, E0, 3); push(0, S_I, E0, 3); step(4);

    // RAM op, then stores
    ifa.ir_op = 3'b001; ifa.run = 1'b1;
    push(0, S_F, EF, 3); push(0, S_D, EO, 3); push(0, S_M, E0, 3);
    push(0, S_E, ER, 3); push(0, S_F, EF, 4); step(5);
    ifa.ir_op = 3'b100;
    push(0, S_D, EO, 4); push(0, S_S, EW, 4); push(0, S_F, EF, 5); step(3);
    ifa.run = 1'b0;
    push(0, S_D, EO, 5); push(0, S_S, EW, 5); push(0, S_I, E0, 6); step(3);

    // single-step a store; a step_req during STORE is dropped
    ifa.step_req = 1'b1; push(0, S_F, EF, 6); step(1);
    ifa.step_req = 1'b0; push(0, S_D, EO, 6); push(0, S_S, EW, 6); step(2);
    ifa.step_req = 1'b1; push(0, S_I, EA, 7); step(1);
    ifa.step_req = 1'b0; push(0, S_I, E0, 7); step(1);

    // single-step an ALU op
    ifa.ir_op = 3'b000;
    ifa.step_req = 1'b1; push(0, S_F, EF, 7); step(1);
    ifa.step_req = 1'b0;
    push(0, S_D, EO, 7); push(0, S_E, ER, 7); push(0, S_I, EA, 8); push(0, S_I, E0, 8); step(4);

    // run and step together: run wins, no ack
    ifa.run = 1'b1; ifa.step_req = 1'b1; push(0, S_F, EF, 8); step(1);
    ifa.step_req = 1'b0; push(0, S_D, EO, 8); push(0, S_E, ER, 8); step(2);
    ifa.run = 1'b0; push(0, S_I, E0, 9); step(1);

    // HALT is sticky until reset
    ifa.ir_op = 3'b111; ifa.run = 1'b1;
    push(0, S_F, EF, 9); push(0, S_D, EO, 9); push(0, S_H, EH, 9); step(3);
    ifa.run = 1'b0; ifa.step_req = 1'b1; push(0, S_H, EH, 9); step(1);
    ifa.run = 1'b1; ifa.step_req = 1'b0; push(0, S_H, EH, 9); step(1);
    ra = 1'b0; push(0, S_I, E0, 0); step(1);
    ra = 1'b1; ifa.run = 1'b0; push(0, S_I, E0, 0); step(1);

    // counter wrap: 257 ALU retires cross 255 -> 0 -> 1
    ifa.ir_op = 3'b000; ifa.run = 1'b1;
    for (int i = 0; i < 257; i++) begin
      push(0, S_F, EF, 8'(i)); push(0, S_D, EO, 8'(i)); push(0, S_E, ER, 8'(i));
    end
    push(0, S_F, EF, 1); step(772);
    ifa.run = 1'b0;
    push(0, S_D, EO, 1); push(0, S_E, ER, 1); push(0, S_I, E0, 2); step(3);

    // ROM_WAIT=3, RAM_WAIT=2: 7 cycles per RAM op
    push(1, S_I, E0, 0); step(1);
    rb = 1'b1; ifb.run = 1'b1; ifb.ir_op = 3'b001;
    push(1, S_F, E0, 0); push(1, S_F, E0, 0); push(1, S_F, EF, 0); push(1, S_D, EO, 0);
    push(1, S_M, E0, 0); push(1, S_M, E0, 0); push(1, S_E, ER, 0); push(1, S_F, E0, 1); step(8);
    ifb.run = 1'b0;
    push(1, S_F, E0, 1); push(1, S_F, EF, 1); push(1, S_D, EO, 1); push(1, S_M, E0, 1);
    push(1, S_M, E0, 1); push(1, S_E, ER, 1); push(1, S_I, E0, 2); step(7);

    // ROM_WAIT=2, RAM_WAIT=3: reset mid-MEMRD, then full restart
    push(2, S_I, E0, 0); step(1);
    rc = 1'b1; ifc.run = 1'b1; ifc.ir_op = 3'b001;
    push(2, S_F, E0, 0); push(2, S_F, EF, 0); push(2, S_D, EO, 0);
    push(2, S_M, E0, 0); push(2, S_M, E0, 0); step(5);
    rc = 1'b0; push(2, S_I, E0, 0); step(1);
    rc = 1'b1;
    push(2, S_F, E0, 0); push(2, S_F, EF, 0); push(2, S_D, EO, 0); push(2, S_M, E0, 0);
    push(2, S_M, E0, 0); push(2, S_M, E0, 0); push(2, S_E, ER, 0); push(2, S_F, E0, 1); step(8);
    ifc.run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_sequencer.md
NIBBLE_SEQUENCER -- requirements
Module: nibble_sequencer

Interface
REQ-001 SHALL have parameter ROM_WAIT, default 1, cycles spent in FETCH (legal 1..3).
REQ-002 SHALL have parameter RAM_WAIT, default 1, cycles spent in MEMRD (legal 1..3).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port run  input  1  level; 1 = free-running execution.
REQ-006 SHALL have port step_req  input  1  single-cycle pulse requesting one instruction.
REQ-007 SHALL have port ir_op  input  3  opcode field of instruction register (inst[23:21]).
REQ-008 SHALL have port fetch_en  output  1  load instruction register and increment PC.
REQ-009 SHALL have port opnd_en  output  1  load op/addr/x/y operand registers.
REQ-010 SHALL have port r_en  output  1  load result register.
REQ-011 SHALL have port ram_we  output  1  write result register into RAM at addr.
REQ-012 SHALL have port step_ack  output  1  one-cycle pulse: stepped instruction complete.
REQ-013 SHALL have port halted  output  1  sequencer in HALT.
REQ-014 SHALL have port state  output  3  current state encoding.
REQ-015 SHALL have port instr_count  output  8  retired-instruction counter.

Function
REQ-016 SHALL implement states IDLE=0, FETCH=1, DECODE=2, MEMRD=3, EXEC=4, STORE=5, HALT=6; code 7 unreachable, recovers to IDLE next cycle.
REQ-017 SHALL drive all enables as decode of registered state (Moore); no enable asserted in IDLE or HALT.
REQ-018 IDLE: run=1 -> FETCH; else step_req=1 -> FETCH with internal step flag set; both high -> run wins, step flag clear, no step_ack.
REQ-019 FETCH: remain ROM_WAIT cycles (wait counter); fetch_en=1 only in last FETCH cycle; then DECODE.
REQ-020 DECODE: one cycle, opnd_en=1; next from ir_op: 3'b111 -> HALT; 3'b100 -> STORE; ir_op[0]=1 -> MEMRD; else EXEC.
REQ-021 MEMRD: remain RAM_WAIT cycles, no enables; then EXEC.
REQ-022 EXEC: one cycle, r_en=1; instruction retires.
REQ-023 STORE: one cycle, ram_we=1; instruction retires.
REQ-024 On retire: step flag set -> IDLE, step_ack=1 for exactly the retire cycle's successor cycle, flag cleared; else run=1 -> FETCH; else -> IDLE.
REQ-025 instr_count SHALL increment by 1 per retire (EXEC or STORE), modulo 256 (255 -> 0); HALT opcode does not count.
REQ-026 HALT: halted=1, stays until reset; run and step_req ignored.
REQ-027 step_req outside IDLE SHALL be ignored and not queued.
REQ-028 run deasserted mid-instruction SHALL let the current instruction finish, then go IDLE.
REQ-029 Instruction latency (run=1, waits=1): ALU op 3 cycles (FETCH, DECODE, EXEC), RAM op 4, STORE 3.

Reset
REQ-030 reset=0 at a clock edge SHALL force state=IDLE, step flag=0, wait counter=0, instr_count=0, all outputs 0, from any state including mid-wait and HALT.
REQ-031 Outputs SHALL be 0 in the first cycle after reset release; no enable pulse generated by reset itself.

Verification
REQ-032 run=1, ir_op=3'b000 held, waits=1 -> state 1,2,4,1,2,4...; fetch_en/opnd_en/r_en one cycle each; instr_count=2 after 6 cycles.
REQ-033 ROM_WAIT=3, RAM_WAIT=2, ir_op=3'b001, run=1 -> FETCH 3 cycles (fetch_en on 3rd only), DECODE, MEMRD 2 cycles, EXEC; 7 cycles/instruction.
REQ-034 run=0, step_req pulse, ir_op=3'b100 -> FETCH, DECODE, STORE (ram_we=1), IDLE with step_ack=1 one cycle; instr_count=1; second step_req during STORE ignored.
REQ-035 ir_op=3'b111, run=1 -> HALT after DECODE, halted=1, instr_count unchanged; toggling run/step_req has no effect; reset=0 one cycle -> state=0, halted=0.
REQ-036 Preload 254 retires, run 3 ALU instructions -> instr_count 255, 0, 1.
REQ-037 reset=0 asserted in MEMRD with RAM_WAIT=3 -> next cycle state=0, all enables 0; run=1 after release restarts at FETCH with full ROM_WAIT.
